mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: TIMEOUT, default 255; BUSY cycles without mem_ack_i before the transaction is aborted (range 2..65535).
REQ-002: STARVE_LIMIT, default 3; consecutive data grants while fetch is pending before fetch is forced (range 1..15).
REQ-003: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_i  input  1  reset; synchronous and active-high.
REQ-005: if_req_i  input  1  fetch read request, held high until if_ack_o.
REQ-006: if_addr_i  input  32  fetch byte address.
REQ-007: if_ack_o / if_err_o  output  1 each  fetch completion pulse / abort flag, valid with if_ack_o.
REQ-008: if_rdata_o  output  32  fetch read data, valid with if_ack_o.
REQ-009: d_req_i / d_we_i  input  1 each  data request, held until d_ack_o / 1 = store.
REQ-010: d_be_i  input  4  store byte enables.
REQ-011: d_addr_i / d_wdata_i  input  32 each  data address / store data.
REQ-012: d_ack_o / d_err_o  output  1 each  data completion pulse / abort flag.
REQ-013: d_rdata_o  output  32  load data, valid with d_ack_o.
REQ-014: mem_req_o / mem_we_o  output  1 each  shared-port request / write.
REQ-015: mem_be_o  output  4; mem_addr_o, mem_wdata_o  output  32 each  registered shared-port fields.
REQ-016: mem_ack_i  input  1; mem_rdata_i  input  32  memory completion and read data.

Function
REQ-017: FSM states SHALL be IDLE, BUSY_I and BUSY_D; one outstanding transaction at most.
REQ-018: In IDLE, only d_req_i high -> BUSY_D; only if_req_i high -> BUSY_I; neither -> IDLE.
REQ-019: In IDLE with both high, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-020: starve_cnt SHALL increment on each data grant made while if_req_i is high (saturating at STARVE_LIMIT), and clear on each fetch grant.
REQ-021: On a grant, the winner's address/we/be/wdata SHALL be registered onto mem_*_o and mem_req_o set to 1 the next cycle.
REQ-022: A fetch grant SHALL drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-023: mem_*_o SHALL be held stable throughout BUSY; requester input changes during BUSY are ignored.
REQ-024: In BUSY_X, owner ack_o = mem_ack_i (combinational), owner rdata_o = mem_rdata_i, and err_o = 0.
REQ-025: Non-owner ack/err SHALL be 0 and its rdata SHALL be 0 at all times.
REQ-026: On mem_ack_i in BUSY, the FSM SHALL return to IDLE; mem_req_o is 0 the following cycle.
REQ-027: mem_ack_i in IDLE SHALL be ignored.
REQ-028: tmo_cnt SHALL clear on grant and increment each BUSY cycle without mem_ack_i.
REQ-029: When tmo_cnt == TIMEOUT in BUSY without ack, owner ack_o=1, err_o=1, rdata_o=0, and the FSM returns to IDLE.
REQ-030: If mem_ack_i coincides with the timeout cycle, the ack wins (err_o=0, normal data).
REQ-031: Minimum latency: request at cycle 0 -> mem_req_o at cycle 1 -> ack_o the same cycle as mem_ack_i; minimum issue spacing is 2 cycles (IDLE between transactions).

Reset
REQ-032: While rst_i is sampled high: FSM=IDLE, starve_cnt=0, tmo_cnt=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-033: While rst_i is sampled high: all ack/err outputs 0 and all rdata outputs 0.
REQ-034: Reset during BUSY SHALL abort silently, with no ack or err pulse, and mem_req_o=0 the next cycle.

Verification
REQ-035: Single fetch: if_req_i=1, if_addr_i=0x100, memory acks 1 cycle after mem_req_o with 0xDEADBEEF -> mem_addr_o=0x100, mem_we_o=0, mem_be_o=F, if_ack_o pulses once with if_rdata_o=0xDEADBEEF.
REQ-036: Store: d_we_i=1, d_be_i=4'b0011, d_addr_i=0x2000, d_wdata_i=0x1234 -> mem fields match exactly, d_ack_o one pulse, if_ack_o stays 0.
REQ-037: Contention, both requesters continuous with STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I...
REQ-038: No mem_ack_i, TIMEOUT=8 -> owner ack_o=1 and err_o=1 exactly 8 cycles after mem_req_o rises; FSM returns to IDLE.
REQ-039: Ack on the timeout cycle -> err_o=0 and rdata delivered.
REQ-040: rst_i pulsed mid-BUSY -> mem_req_o=0 next cycle, no ack; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter between a fetch requester and a data requester.
// One outstanding transaction, data-priority with a starvation guard, and a BUSY timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic        if_err_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [15:0] TMO_MAX    = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        grant_d, grant_i, tmo_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // An ack arriving on the timeout cycle takes precedence over the abort.
    always_comb begin
        grant_d = d_req_i && !(if_req_i && starve_q == STARVE_MAX);
        grant_i = if_req_i && !grant_d;
        tmo_hit = (state_q != IDLE) && (tmo_q == TMO_MAX) && !mem_ack_i;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = BUSY_D;
                else if (grant_i) state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack_i || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == IDLE) begin
            tmo_d = '0;
            if (grant_d) begin
                mem_we_d    = d_we_i;
                mem_be_d    = d_be_i;
                mem_addr_d  = d_addr_i;
                mem_wdata_d = d_wdata_i;
                if (if_req_i && starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
            end else if (grant_i) begin
                mem_we_d    = 1'b0;
                mem_be_d    = 4'hF;
                mem_addr_d  = if_addr_i;
                mem_wdata_d = '0;
                starve_d    = '0;
            end
        end else if (!mem_ack_i) begin
            tmo_d = tmo_q + 16'd1;
        end
        mem_req_d = (state_d != IDLE);
    end

    always_comb begin
        if_ack_o   = 1'b0;
        if_err_o   = 1'b0;
        if_rdata_o = '0;
        d_ack_o    = 1'b0;
        d_err_o    = 1'b0;
        d_rdata_o  = '0;
        if (!rst_i) begin
            case (state_q)
                BUSY_I: begin
                    if_ack_o   = mem_ack_i || tmo_hit;
                    if_err_o   = tmo_hit;
                    if_rdata_o = tmo_hit ? '0 : mem_rdata_i;
                end
                BUSY_D: begin
                    d_ack_o   = mem_ack_i || tmo_hit;
                    d_err_o   = tmo_hit;
                    d_rdata_o = tmo_hit ? '0 : mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule
